dmem_responder: RTL and testbench
=================================

# dmem_responder

Memory-side responder for the core's data-memory port: it accepts one load or store request at a time, waits a programmable access latency, performs the access on an internal word array with RV32 byte/half/word semantics, and returns a response. It sits between the core's load/store path (MemWr/MemOp/ALU-address signals) and the rest of the system, closing the path that today writes 32'b0 when MemToReg is set.

## Interface
- DEPTH, 1024: number of 32-bit words in the array.
- BASE_ADDR, 32'h80000000: byte address of word 0.
- LATENCY, 1: cycles between acceptance and commit, legal range 1..15.

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous and active-low (asserted when 0).
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_wen  in  1  1 = store, 0 = load.
- req_op  in  3  RV32 funct3: 000 b, 001 h, 010 w, 100 bu, 101 hu.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_rdata  out  32  load result, extended to 32 bits; 0 for stores and errors.
- rsp_err  out  1  request rejected: misaligned, out of range, or illegal op.

## Operation
- FSM states: IDLE, BUSY, RESP. req_ready = (state == IDLE). rsp_valid = (state == RESP).
- IDLE: on req_valid && req_ready, latch wen/op/addr/wdata, load counter with LATENCY-1, go to BUSY.
- BUSY: decrement counter each cycle. At the edge where the counter is 0, commit, latch rsp_rdata/rsp_err, go to RESP.
- RESP: hold rsp_valid, rsp_rdata and rsp_err stable until rsp_ready. On rsp_valid && rsp_ready, go to IDLE.
- Word index = (addr - BASE_ADDR) >> 2. In range iff BASE_ADDR <= addr < BASE_ADDR + 4*DEPTH, compared on the full 32-bit unsigned value.
- Error conditions, OR-ed together into rsp_err:
  - op is 011, 110 or 111;
  - a store with op 100 or 101;
  - h/hu with addr[0] = 1;
  - w with addr[1:0] != 0;
  - address out of range.
- On error, nothing is written and rsp_rdata = 0.
- Stores:
  - sb writes wdata[7:0] into byte lane addr[1:0].
  - sh writes wdata[15:0] into lanes {addr[1],0} and {addr[1],1}.
  - sw writes all four lanes.
  - Other lanes are unchanged. rsp_rdata = 0.
- Loads: select byte at addr[1:0] or half at addr[1]. b/h sign-extend; bu/hu zero-extend; w returns the full word.
- Array contents are not reset. Only control state and outputs are reset.
- Request inputs are sampled only at acceptance. Changes while in BUSY or RESP are ignored.

## Timing
- Reset values: state IDLE, req_ready 1, rsp_valid 0, rsp_rdata 0, rsp_err 0, counter 0.
- Reset takes effect immediately (asynchronous) and deasserts synchronously to clk.
- Accept at edge k; commit at edge k+LATENCY; rsp_valid high from edge k+LATENCY until the handshake edge.
- With rsp_ready held high, the handshake occurs at edge k+LATENCY+1 and req_ready is high after it. Minimum spacing between accepts is LATENCY+2 cycles.
- One outstanding transaction. req_ready stays low through BUSY and RESP, including the handshake cycle, so there is no same-cycle turnaround.
- Load-after-store to the same address returns the stored data, because the store commits before the next request can be accepted.
- Reset asserted in BUSY: the transaction is dropped and no write occurs. Reset asserted in RESP: the response is discarded. Writes already committed remain in the array.
- Backpressure: a response held any number of cycles keeps its data and error flag unchanged.

## Test plan
- Reset, then sw addr 0x80000010 wdata 0xDEADBEEF, then lw 0x80000010 -> rsp_rdata 0xDEADBEEF, rsp_err 0; with LATENCY=1 each rsp_valid rises 1 cycle after acceptance.
- Store 0x80000010 = 0xDEADBEEF, then sb 0x80000011 wdata 0x55. Then:
  - lw -> 0xDEAD55EF;
  - lb 0x80000013 -> 0xFFFFFFDE;
  - lbu 0x80000013 -> 0x000000DE;
  - lh 0x80000012 -> 0xFFFFDEAD;
  - lhu 0x80000012 -> 0x0000DEAD.
- Errors, each -> rsp_err 1, rsp_rdata 0, memory unchanged on a later lw:
  - lw 0x80000012;
  - sh 0x80000011;
  - lw 0x7FFFFFFC;
  - lw BASE_ADDR + 4*DEPTH;
  - op 011.
- LATENCY=4, rsp_ready low 5 cycles after rsp_valid rises:
  - rsp_valid rises 4 cycles after acceptance;
  - rsp_valid and rsp_rdata stay stable and req_ready stays 0 while rsp_ready is low;
  - req_ready returns 1 the cycle after the handshake.
- Issue sw 0x80000020 = 0x12345678 with LATENCY=4, and assert rst after 2 BUSY cycles:
  - immediately rsp_valid 0 and req_ready 1;
  - a later lw 0x80000020 returns the prior contents, not 0x12345678.
- Random back-to-back loads/stores with random rsp_ready stalls, checked against a reference byte-array model:
  - every response matches the model;
  - no two accepts are fewer than LATENCY+2 cycles apart.

Source files
------------

// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding RV32 load/store against an internal
// word array, with a programmable commit latency and a held response.
module dmem_responder #(
    parameter int          DEPTH     = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h80000000,
    parameter int          LATENCY   = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t      state, state_nxt;
    logic [3:0]  cnt;
    logic        wen;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mem [DEPTH];

    logic [31:0] offset;
    logic [AW-1:0] idx;
    logic        in_range;
    logic        err;
    logic        commit;
    logic [31:0] word;
    logic [7:0]  ld_b;
    logic [15:0] ld_h;
    logic [31:0] ld_data;
    logic [31:0] st_data;
    logic [3:0]  be;

    assign offset   = addr - BASE_ADDR;
    assign idx      = AW'(offset >> 2);
    // 33-bit compare so a base near the top of the address space cannot wrap
    assign in_range = (addr >= BASE_ADDR) &&
                      ({1'b0, addr} < ({1'b0, BASE_ADDR} + 33'(DEPTH) * 33'd4));

    assign err = (op == 3'b011) || (op[2:1] == 2'b11) || (wen && op[2]) ||
                 ((op[1:0] == 2'b01) && addr[0]) ||
                 ((op[1:0] == 2'b10) && (addr[1:0] != 2'b00)) ||
                 !in_range;

    assign commit    = (state == BUSY) && (cnt == 4'd0);
    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);

    assign word = mem[idx];
    assign ld_b = word[{addr[1:0], 3'b000} +: 8];
    assign ld_h = word[{addr[1], 4'b0000} +: 16];

    always_comb begin
        ld_data = word;
        case (op[1:0])
            2'b00:   ld_data = op[2] ? {24'b0, ld_b} : {{24{ld_b[7]}}, ld_b};
            2'b01:   ld_data = op[2] ? {16'b0, ld_h} : {{16{ld_h[15]}}, ld_h};
            default: ld_data = word;
        endcase
    end

    // Store data is replicated across lanes so the byte enables alone pick the target.
    always_comb begin
        be      = 4'b1111;
        st_data = wdata;
        case (op[1:0])
            2'b00: begin
                be      = 4'b0001 << addr[1:0];
                st_data = {4{wdata[7:0]}};
            end
            2'b01: begin
                be      = addr[1] ? 4'b1100 : 4'b0011;
                st_data = {2{wdata[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_valid)   state_nxt = BUSY;
            BUSY:    if (cnt == 4'd0) state_nxt = RESP;
            RESP:    if (rsp_ready)   state_nxt = IDLE;
            default:                  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && req_valid)
                cnt <= 4'(LATENCY - 1);
            else if (state == BUSY && cnt != 4'd0)
                cnt <= cnt - 4'd1;
            if (commit) begin
                rsp_err   <= err;
                rsp_rdata <= (wen || err) ? 32'd0 : ld_data;
            end
        end
    end

    // Request fields are captured only on acceptance; later input changes are ignored.
    always_ff @(posedge clk) begin
        if (req_valid && req_ready) begin
            wen   <= req_wen;
            op    <= req_op;
            addr  <= req_addr;
            wdata <= req_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (commit && wen && !err) begin
            for (int i = 0; i < 4; i++)
                if (be[i]) mem[idx][8*i +: 8] <= st_data[8*i +: 8];
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (LATENCY 1 and 4), a queue-based
// scoreboard popped by per-instance monitors, and a byte-array reference model.
module tb_dmem_responder;

    localparam logic [31:0] BASE = 32'h80000000;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    logic        rst       [2];
    logic        req_valid [2];
    logic        req_wen   [2];
    logic [2:0]  req_op    [2];
    logic [31:0] req_addr  [2];
    logic [31:0] req_wdata [2];
    logic        req_ready [2];
    logic        rsp_valid [2];
    logic        rsp_err   [2];
    logic [31:0] rsp_rdata [2];

    logic rand_en = 1'b0;
    logic rnd_rdy = 1'b1;
    logic rdy1    = 1'b1;
    wire  rdy0    = rand_en ? rnd_rdy : 1'b1;

    int n_cmp = 0;
    int n_bad = 0;
    int last_acc = -1;
    exp_t q0[$];
    exp_t q1[$];
    logic [7:0] mdl [logic [31:0]];

    dmem_responder #(.DEPTH(1024), .BASE_ADDR(BASE), .LATENCY(1)) u_l1 (
        .clk(clk), .rst(rst[0]),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_wen(req_wen[0]),
        .req_op(req_op[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rdy0),
        .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
    );

    dmem_responder #(.DEPTH(64), .BASE_ADDR(BASE), .LATENCY(4)) u_l4 (
        .clk(clk), .rst(rst[1]),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_wen(req_wen[1]),
        .req_op(req_op[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rdy1),
        .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h want=%h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic timeout(input string nm);
        n_cmp++;
        n_bad++;
        $display("FAIL %s timed out (cycle %0d)", nm, cyc);
    endtask

    // Byte-addressed reference: decides error, applies stores, assembles loads.
    function automatic exp_t model(input logic wen, input logic [2:0] op,
                                   input logic [31:0] a, input logic [31:0] wd);
        exp_t r;
        int n;
        logic [31:0] v;
        r.rdata = 32'd0;
        r.err = (op == 3'd3) || (op >= 3'd6) || (wen && op >= 3'd4) ||
                ((op == 3'd1 || op == 3'd5) && a[0]) ||
                (op == 3'd2 && a[1:0] != 2'b00) ||
                (a < BASE) || (a >= BASE + 32'h1000);
        n = (op[1:0] == 2'b00) ? 1 : (op[1:0] == 2'b01) ? 2 : 4;
        if (!r.err) begin
            if (wen) begin
                for (int b = 0; b < n; b++) mdl[a + 32'(b)] = wd[8*b +: 8];
            end else begin
                v = 32'd0;
                for (int b = 0; b < n; b++) v[8*b +: 8] = mdl[a + 32'(b)];
                if (op == 3'd0) v = {{24{v[7]}}, v[7:0]};
                if (op == 3'd1) v = {{16{v[15]}}, v[15:0]};
                r.rdata = v;
            end
        end
        return r;
    endfunction

    // Returns just after the accepting edge.
    task automatic issue(input int i, input logic wen, input logic [2:0] op,
                         input logic [31:0] a, input logic [31:0] wd,
                         input exp_t e, input bit push);
        int n = 0;
        req_wen[i]   = wen;
        req_op[i]    = op;
        req_addr[i]  = a;
        req_wdata[i] = wd;
        req_valid[i] = 1'b1;
        @(negedge clk);
        while (!req_ready[i] && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            timeout("req_accept");
            req_valid[i] = 1'b0;
            return;
        end
        if (push) begin
            if (i == 0) q0.push_back(e);
            else        q1.push_back(e);
        end
        @(posedge clk);
        #1 req_valid[i] = 1'b0;
        req_wdata[i] = 32'hxxxxxxxx;
        req_addr[i]  = $urandom;
    endtask

    task automatic rise_lat(input int i, input int lat);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rsp_valid[i] && n < 50);
        if (n >= 50) timeout("rsp_rise");
        else chk($sformatf("rsp_latency%0d", i), 32'(n - 1), 32'(lat));
    endtask

    task automatic wait_idle(input int i);
        int n = 0;
        @(negedge clk);
        while (!(req_ready[i] && ((i == 0) ? q0.size() == 0 : q1.size() == 0)) && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) timeout("drain");
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t ex(input logic [31:0] d, input logic e);
        exp_t r;
        r.rdata = d;
        r.err   = e;
        return r;
    endfunction

    always @(negedge clk) begin
        if (rst[0] && rsp_valid[0] && rdy0) begin
            if (q0.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL rsp0_unexpected got=%h", rsp_rdata[0]);
            end else begin
                exp_t e;
                e = q0.pop_front();
                chk("rsp0_rdata", rsp_rdata[0], e.rdata);
                chk("rsp0_err", 32'(rsp_err[0]), 32'(e.err));
            end
        end
    end

    always @(negedge clk) begin
        if (rst[1] && rsp_valid[1] && rdy1) begin
            if (q1.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL rsp1_unexpected got=%h", rsp_rdata[1]);
            end else begin
                exp_t e;
                e = q1.pop_front();
                chk("rsp1_rdata", rsp_rdata[1], e.rdata);
                chk("rsp1_err", 32'(rsp_err[1]), 32'(e.err));
            end
        end
    end

    // Accept spacing on the LATENCY=1 instance must be at least 3 cycles.
    always @(negedge clk) begin
        if (rst[0] && req_valid[0] && req_ready[0]) begin
            if (last_acc >= 0) chk("accept_spacing_ok", 32'(cyc - last_acc >= 3), 32'd1);
            last_acc = cyc;
        end
    end

    always @(posedge clk) begin
        #1 rnd_rdy = 1'($urandom_range(0, 1));
    end

    initial begin
        exp_t e;
        logic [2:0] ops [6];
        ops[0] = 3'd0; ops[1] = 3'd1; ops[2] = 3'd2;
        ops[3] = 3'd4; ops[4] = 3'd5; ops[5] = 3'd3;

        for (int i = 0; i < 2; i++) begin
            rst[i] = 1'b1; req_valid[i] = 1'b0; req_wen[i] = 1'b0;
            req_op[i] = 3'd0; req_addr[i] = 32'd0; req_wdata[i] = 32'd0;
        end
        #2 rst[0] = 1'b0; rst[1] = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("reset_req_ready", 32'(req_ready[i]), 32'd1);
            chk("reset_rsp_valid", 32'(rsp_valid[i]), 32'd0);
            chk("reset_rsp_rdata", rsp_rdata[i], 32'd0);
            chk("reset_rsp_err", 32'(rsp_err[i]), 32'd0);
        end
        @(negedge clk);
        rst[0] = 1'b1; rst[1] = 1'b1;
        @(posedge clk); #1;

        // LATENCY=1 directed
        issue(0, 1'b1, 3'd2, 32'h80000010, 32'hDEADBEEF, ex(32'd0, 1'b0), 1);
        rise_lat(0, 1);
        issue(0, 1'b0, 3'd2, 32'h80000010, 32'd0, ex(32'hDEADBEEF, 1'b0), 1);
        rise_lat(0, 1);
        issue(0, 1'b1, 3'd0, 32'h80000011, 32'hAAAAAA55, ex(32'd0, 1'b0), 1);
        issue(0, 1'b0, 3'd2, 32'h80000010, 32'd0, ex(32'hDEAD55EF, 1'b0), 1);
        issue(0, 1'b0, 3'd0, 32'h80000013, 32'd0, ex(32'hFFFFFFDE, 1'b0), 1);
        issue(0, 1'b0, 3'd4, 32'h80000013, 32'd0, ex(32'h000000DE, 1'b0), 1);
        issue(0, 1'b0, 3'd1, 32'h80000012, 32'd0, ex(32'hFFFFDEAD, 1'b0), 1);
        issue(0, 1'b0, 3'd5, 32'h80000012, 32'd0, ex(32'h0000DEAD, 1'b0), 1);
        issue(0, 1'b0, 3'd2, 32'h80000012, 32'd0, ex(32'd0, 1'b1), 1);
        issue(0, 1'b1, 3'd1, 32'h80000011, 32'h0000FFFF, ex(32'd0, 1'b1), 1);
        issue(0, 1'b0, 3'd2, 32'h7FFFFFFC, 32'd0, ex(32'd0, 1'b1), 1);
        issue(0, 1'b0, 3'd2, 32'h80001000, 32'd0, ex(32'd0, 1'b1), 1);
        issue(0, 1'b0, 3'd3, 32'h80000010, 32'd0, ex(32'd0, 1'b1), 1);
        issue(0, 1'b1, 3'd4, 32'h80000010, 32'h00000011, ex(32'd0, 1'b1), 1);
        issue(0, 1'b0, 3'd2, 32'h80000010, 32'd0, ex(32'hDEAD55EF, 1'b0), 1);
        wait_idle(0);

        // LATENCY=4: backpressure
        issue(1, 1'b1, 3'd2, 32'h80000020, 32'hCAFEF00D, ex(32'd0, 1'b0), 1);
        issue(1, 1'b1, 3'd2, 32'h80000024, 32'hA5A5A5A5, ex(32'd0, 1'b0), 1);
        wait_idle(1);
        rdy1 = 1'b0;
        issue(1, 1'b0, 3'd2, 32'h80000024, 32'd0, ex(32'hA5A5A5A5, 1'b0), 1);
        rise_lat(1, 4);
        for (int j = 0; j < 5; j++) begin
            chk("stall_rsp_valid", 32'(rsp_valid[1]), 32'd1);
            chk("stall_rsp_rdata", rsp_rdata[1], 32'hA5A5A5A5);
            chk("stall_rsp_err", 32'(rsp_err[1]), 32'd0);
            chk("stall_req_ready", 32'(req_ready[1]), 32'd0);
            @(posedge clk);
            if (j < 4) @(negedge clk);
        end
        #1 rdy1 = 1'b1;
        @(negedge clk);
        chk("hs_cycle_req_ready", 32'(req_ready[1]), 32'd0);
        @(negedge clk);
        chk("post_hs_req_ready", 32'(req_ready[1]), 32'd1);
        chk("post_hs_rsp_valid", 32'(rsp_valid[1]), 32'd0);
        @(posedge clk); #1;

        // LATENCY=4: reset during BUSY drops the store
        issue(1, 1'b1, 3'd2, 32'h80000020, 32'h12345678, ex(32'd0, 1'b0), 0);
        @(posedge clk);
        @(posedge clk);
        #1 rst[1] = 1'b0;
        #1;
        chk("rst_busy_rsp_valid", 32'(rsp_valid[1]), 32'd0);
        chk("rst_busy_req_ready", 32'(req_ready[1]), 32'd1);
        @(negedge clk);
        rst[1] = 1'b1;
        @(posedge clk); #1;
        issue(1, 1'b0, 3'd2, 32'h80000020, 32'd0, ex(32'hCAFEF00D, 1'b0), 1);
        wait_idle(1);

        // LATENCY=1 random traffic against the byte model
        for (int w = 0; w < 16; w++) begin
            logic [31:0] d;
            d = $urandom;
            e = model(1'b1, 3'd2, 32'h80000100 + 32'(4 * w), d);
            issue(0, 1'b1, 3'd2, 32'h80000100 + 32'(4 * w), d, e, 1);
        end
        rand_en = 1'b1;
        for (int k = 0; k < 80; k++) begin
            logic wen;
            logic [2:0] op;
            logic [31:0] a, d;
            int r;
            wen = 1'($urandom_range(0, 1));
            op  = ops[$urandom_range(0, 5)];
            r   = $urandom_range(0, 9);
            a   = (r == 0) ? 32'h80001000 + 32'($urandom_range(0, 7)) :
                  (r == 1) ? 32'h7FFFFFF8 + 32'($urandom_range(0, 7)) :
                             32'h80000100 + 32'($urandom_range(0, 63));
            d   = $urandom;
            e   = model(wen, op, a, d);
            issue(0, wen, op, a, d, e, 1);
        end
        wait_idle(0);
        rand_en = 1'b0;
        wait_idle(0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout cycle=%0d", cyc);
        $fatal(1, "timeout");
    end

endmodule
